figaro_read_arbiter: RTL and testbench

Two-port read arbiter and refill sequencer for the FiGaRO/SHA3 random-number core. It owns the core's `enable`, `ready`, `ADDR` and `DATA_OUT` pins and serves each 32-bit digest word to exactly one of two requesters, using round-robin order. When all words of a digest are used, it restarts the core to produce a fresh digest. It sits between the FiGaRO_SHA3 instance and the system-side consumers.

---
 rtl/figaro_read_arbiter.sv | 158 +++++++++++++++
 tb/tb_figaro_read_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/figaro_read_arbiter.sv
// Two-port round-robin read arbiter and refill sequencer for the FiGaRO/SHA3 RNG core.
// Optional repetition-count health test enabled by defining FIGARO_ARB_HEALTH_EN.
//
// state     | meaning
// S_START   | first cycle after reset, turn the core on
// S_WAIT_LOW| wait for the core to drop ready after a restart
// S_WAIT_HIGH| wait for a fresh digest
// S_AVAIL   | digest available, arbitrate requesters
// S_READ    | core_addr presented, capture core_data
// S_RESP    | deliver the word to the granted requester
// S_REFILL  | one-cycle enable-low pulse to restart the core
module figaro_read_arbiter #(
  parameter int WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  output logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] req1_data,
  output logic        core_enable,
  input  logic        core_ready,
  output logic [9:0]  core_addr,
  input  logic [31:0] core_data,
  output logic [15:0] words_served,
  output logic        health_fail
);

  typedef enum logic [2:0] {
    S_START,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_AVAIL,
    S_READ,
    S_RESP,
    S_REFILL
  } state_t;

  localparam logic [9:0] LAST_PTR = 10'(WORDS - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_core_enable;
  logic [9:0]  r_core_addr;
  logic [9:0]  r_ptr;
  logic        r_grant;
  logic        r_last_grant;
  logic [31:0] r_data_q;
  logic [15:0] r_words_served;

  logic        w_any_req;
  logic        w_sel;
  logic        w_rep;
  logic        w_deliver;
  logic        w_last_word;

  assign w_any_req   = req0_valid | req1_valid;
  // On a tie the requester that did not win last time gets the word.
  assign w_sel       = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_deliver   = (r_state == S_RESP) & ~w_rep;
  assign w_last_word = (r_ptr == LAST_PTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:     w_next = S_WAIT_HIGH;
      S_WAIT_LOW:  if (!core_ready) w_next = S_WAIT_HIGH;
      S_WAIT_HIGH: if (core_ready) w_next = S_AVAIL;
      S_AVAIL:     if (w_any_req) w_next = S_READ;
      S_READ:      w_next = S_RESP;
      S_RESP:      w_next = w_last_word ? S_REFILL : S_AVAIL;
      S_REFILL:    w_next = S_WAIT_LOW;
      default:     w_next = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_enable  <= 1'b0;
      r_core_addr    <= '0;
      r_ptr          <= '0;
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_data_q       <= '0;
      r_words_served <= '0;
    end else begin
      case (r_state)
        S_START: r_core_enable <= 1'b1;
        S_WAIT_HIGH: begin
          if (core_ready) r_ptr <= '0;
        end
        S_AVAIL: begin
          if (w_any_req) begin
            r_core_addr <= r_ptr;
            r_grant     <= w_sel;
          end
        end
        S_READ: r_data_q <= core_data;
        S_RESP: begin
          if (w_deliver) begin
            r_last_grant   <= r_grant;
            r_words_served <= r_words_served + 16'd1;
          end
          // A suppressed word is still consumed, so the pointer always moves on.
          if (w_last_word) r_core_enable <= 1'b0;
          else             r_ptr <= r_ptr + 10'd1;
        end
        S_REFILL: r_core_enable <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FIGARO_ARB_HEALTH_EN
  logic [31:0] r_prev_word;
  logic        r_prev_valid;
  logic        r_health_fail;

  assign w_rep = (r_state == S_RESP) & r_prev_valid & (r_data_q == r_prev_word);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_word   <= '0;
      r_prev_valid  <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (r_state == S_RESP) begin
      if (w_rep) begin
        r_health_fail <= 1'b1;
      end else begin
        r_prev_word  <= r_data_q;
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign health_fail = r_health_fail;
`else
  assign w_rep       = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign req0_ready   = w_deliver & ~r_grant;
  assign req1_ready   = w_deliver & r_grant;
  assign req0_data    = r_data_q;
  assign req1_data    = r_data_q;
  assign core_enable  = r_core_enable;
  assign core_addr    = r_core_addr;
  assign words_served = r_words_served;

endmodule

// File: tb/tb_figaro_read_arbiter.sv
// Directed bench for figaro_read_arbiter with a behavioural FiGaRO core model.
// Expected words are {8'hC0, generation, 6'b0, address}; generation advances on each core restart.
module tb_figaro_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        core_enable;
  logic        core_ready = 1'b0;
  logic [9:0]  core_addr;
  logic [31:0] core_data;
  logic [15:0] words_served;
  logic        health_fail;

`ifdef FIGARO_ARB_HEALTH_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif

  always #5 clk = ~clk;

  figaro_read_arbiter #(.WORDS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_data    (req1_data),
    .core_enable  (core_enable),
    .core_ready   (core_ready),
    .core_addr    (core_addr),
    .core_data    (core_data),
    .words_served (words_served),
    .health_fail  (health_fail)
  );

  function automatic logic [31:0] word(input logic [7:0] g, input logic [9:0] a);
    return {8'hC0, g, 6'd0, a};
  endfunction

  // Core model: ready rises 5 cycles after enable, drops when enable is low.
  logic [7:0] gen = 8'd0;
  int         rdy_cnt = 0;
  bit         health_mode = 1'b0;

  always @(posedge clk) begin
    if (!core_enable) begin
      if (core_ready) gen <= gen + 8'd1;
      core_ready <= 1'b0;
      rdy_cnt    <= 0;
    end else if (!core_ready) begin
      if (rdy_cnt == 4) core_ready <= 1'b1;
      else              rdy_cnt <= rdy_cnt + 1;
    end
  end

  assign core_data = (health_mode && (core_addr == 10'd2 || core_addr == 10'd3))
                     ? 32'hDEADBEEF : word(gen, core_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: both ready high, and lengths of enable-low runs after start-up.
  bit both_hi = 1'b0;
  bit en_seen = 1'b0;
  int low_run = 0;
  int n_low = 0;
  int max_low = 0;

  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_hi <= 1'b1;
    if (reset) begin
      en_seen <= 1'b0;
      low_run <= 0;
    end else if (core_enable) begin
      en_seen <= 1'b1;
      if (low_run > 0) begin
        n_low <= n_low + 1;
        if (low_run > max_low) max_low <= low_run;
      end
      low_run <= 0;
    end else if (en_seen) begin
      low_run <= low_run + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // port = 2 signals that no ready pulse arrived within the budget.
  task automatic wait_pulse(output int port, output logic [31:0] data, output int at);
    port = 2;
    data = '0;
    at   = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        port = 0; data = req0_data; at = cyc; return;
      end
      if (req1_ready) begin
        port = 1; data = req1_data; at = cyc; return;
      end
    end
  endtask

  typedef struct {
    logic       v0;
    logic       v1;
    int         port;
    logic [7:0] g;
    logic [9:0] a;
  } vec_t;

  vec_t vq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          p;
    int          t0, t1;
    logic [31:0] d;

    // Arbitration table: remainder of digest 0, all of digest 1, part of digest 2.
    vq.push_back('{1'b1, 1'b1, 1, 8'd0, 10'd3});
    vq.push_back('{1'b1, 1'b1, 0, 8'd0, 10'd4});
    vq.push_back('{1'b1, 1'b1, 1, 8'd0, 10'd5});
    vq.push_back('{1'b1, 1'b1, 0, 8'd0, 10'd6});
    vq.push_back('{1'b1, 1'b1, 1, 8'd0, 10'd7});
    vq.push_back('{1'b1, 1'b1, 0, 8'd1, 10'd0});
    vq.push_back('{1'b1, 1'b1, 1, 8'd1, 10'd1});
    vq.push_back('{1'b1, 1'b1, 0, 8'd1, 10'd2});
    vq.push_back('{1'b1, 1'b1, 1, 8'd1, 10'd3});
    vq.push_back('{1'b1, 1'b1, 0, 8'd1, 10'd4});
    vq.push_back('{1'b1, 1'b1, 1, 8'd1, 10'd5});
    vq.push_back('{1'b1, 1'b1, 0, 8'd1, 10'd6});
    vq.push_back('{1'b1, 1'b1, 1, 8'd1, 10'd7});
    vq.push_back('{1'b1, 1'b0, 0, 8'd2, 10'd0});
    vq.push_back('{1'b0, 1'b1, 1, 8'd2, 10'd1});
    vq.push_back('{1'b0, 1'b1, 1, 8'd2, 10'd2});
    vq.push_back('{1'b1, 1'b1, 0, 8'd2, 10'd3});
    vq.push_back('{1'b1, 1'b1, 1, 8'd2, 10'd4});
    vq.push_back('{1'b1, 1'b0, 0, 8'd2, 10'd5});

    repeat (3) @(negedge clk);
    check("rst enable", 32'(core_enable), 32'd0);
    check("rst addr", 32'(core_addr), 32'd0);
    check("rst ready0", 32'(req0_ready), 32'd0);
    check("rst ready1", 32'(req1_ready), 32'd0);
    check("rst data0", req0_data, 32'd0);
    check("rst data1", req1_data, 32'd0);
    check("rst served", 32'(words_served), 32'd0);
    check("rst health", 32'(health_fail), 32'd0);

    reset = 1'b0;
    @(negedge clk);
    check("start enable", 32'(core_enable), 32'd1);

    // Single requester: three consecutive words, one every 3 cycles.
    req0_valid = 1'b1;
    wait_pulse(p, d, t0);
    check("seq0 port", 32'(p), 32'd0);
    check("seq0 data", d, word(8'd0, 10'd0));
    wait_pulse(p, d, t1);
    check("seq1 port", 32'(p), 32'd0);
    check("seq1 data", d, word(8'd0, 10'd1));
    check("seq1 spacing", 32'(t1 - t0), 32'd3);
    wait_pulse(p, d, t0);
    check("seq2 port", 32'(p), 32'd0);
    check("seq2 data", d, word(8'd0, 10'd2));
    check("seq2 spacing", 32'(t0 - t1), 32'd3);
    req0_valid = 1'b0;
    @(negedge clk);
    check("seq served", 32'(words_served), 32'd3);

    foreach (vq[i]) begin
      req0_valid = vq[i].v0;
      req1_valid = vq[i].v1;
      wait_pulse(p, d, t0);
      check($sformatf("vec%0d port", i), 32'(p), 32'(vq[i].port));
      check($sformatf("vec%0d data", i), d, word(vq[i].g, vq[i].a));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("refill count", 32'(n_low), 32'd2);
    check("refill low width", 32'(max_low), 32'd1);
    check("table served", 32'(words_served), 32'd22);

    // Reset while a word is being delivered.
    req0_valid = 1'b1;
    wait_pulse(p, d, t0);
    check("pre-rst data", d, word(8'd2, 10'd6));
    #2 reset = 1'b1;
    #1;
    check("midrst ready0", 32'(req0_ready), 32'd0);
    check("midrst ready1", 32'(req1_ready), 32'd0);
    check("midrst enable", 32'(core_enable), 32'd0);
    check("midrst served", 32'(words_served), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post-rst enable", 32'(core_enable), 32'd1);
    wait_pulse(p, d, t0);
    check("post-rst port", 32'(p), 32'd0);
    check("post-rst data", d, word(8'd3, 10'd0));
    req0_valid = 1'b0;
    @(negedge clk);
    check("post-rst served", 32'(words_served), 32'd1);

    // Counter wrap: preload just below the top of the range.
    force dut.r_words_served = 16'hFFFE;
    #1;
    release dut.r_words_served;
    check("preload", 32'(words_served), 32'h0000FFFE);
    req0_valid = 1'b1;
    wait_pulse(p, d, t0);
    check("wrap0 data", d, word(8'd3, 10'd1));
    @(negedge clk);
    check("wrap0 served", 32'(words_served), 32'h0000FFFF);
    wait_pulse(p, d, t0);
    check("wrap1 data", d, word(8'd3, 10'd2));
    req0_valid = 1'b0;
    @(negedge clk);
    check("wrap1 served", 32'(words_served), 32'd0);

    // Repeated word at addresses 2 and 3 of a fresh digest.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    health_mode = 1'b1;
    req0_valid = 1'b1;
    wait_pulse(p, d, t0);
    check("rep0 data", d, word(8'd4, 10'd0));
    wait_pulse(p, d, t0);
    check("rep1 data", d, word(8'd4, 10'd1));
    wait_pulse(p, d, t0);
    check("rep2 data", d, 32'hDEADBEEF);
    check("rep2 health", 32'(health_fail), 32'd0);
    wait_pulse(p, d, t0);
    check("rep3 port", 32'(p), 32'd0);
    check("rep3 data", d, HE ? word(8'd4, 10'd4) : 32'hDEADBEEF);
    check("rep3 health", 32'(health_fail), 32'(HE));
    wait_pulse(p, d, t0);
    check("rep4 data", d, HE ? word(8'd4, 10'd5) : word(8'd4, 10'd4));
    req0_valid = 1'b0;
    health_mode = 1'b0;
    @(negedge clk);
    check("rep served", 32'(words_served), 32'd5);
    check("rep health sticky", 32'(health_fail), 32'(HE));

    check("ready exclusive", 32'(both_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
